// File: rtl/sram_req_ctrl.sv
// Front end for a 16-bit asynchronous SRAM: turns single-beat valid/ready requests into timed
// active-low we/oe strobes and owns the shared data bus so that it never contends with the SRAM.
module sram_req_ctrl #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int WE_CYCLES = 2,
   parameter int OE_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic              mem_oe,
   inout  wire  [DATA_W-1:0] mem_data,
   output logic              busy
);

   localparam int MAX_CYC = (WE_CYCLES > OE_CYCLES) ? WE_CYCLES : OE_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_CYCLES - 1);
   localparam logic [CNT_W-1:0] OE_LAST = CNT_W'(OE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_SETUP,
      S_WR_PULSE,
      S_WR_HOLD,
      S_RD_SETUP,
      S_RD_STROBE,
      S_RD_DONE
   } state_t;

   state_t            state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic              bus_drive_reg;
   logic              we_n_reg;
   logic              oe_n_reg;
   logic              rsp_valid_reg;
   logic [DATA_W-1:0] rdata_reg;
   logic              ready_reg;
   logic              busy_reg;

   // Every strobe and the bus enable come straight from flops so the pins never glitch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= S_IDLE;
         cnt_reg       <= '0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         bus_drive_reg <= 1'b0;
         we_n_reg      <= 1'b1;
         oe_n_reg      <= 1'b1;
         rsp_valid_reg <= 1'b0;
         rdata_reg     <= '0;
         ready_reg     <= 1'b1;
         busy_reg      <= 1'b0;
      end else begin
         rsp_valid_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (req_valid) begin
                  addr_reg  <= req_addr;
                  wdata_reg <= req_wdata;
                  cnt_reg   <= '0;
                  ready_reg <= 1'b0;
                  busy_reg  <= 1'b1;
                  if (req_we) begin
                     state_reg     <= S_WR_SETUP;
                     bus_drive_reg <= 1'b1;
                  end else begin
                     state_reg <= S_RD_SETUP;
                  end
               end
            end

            S_WR_SETUP: begin
               state_reg <= S_WR_PULSE;
               we_n_reg  <= 1'b0;
            end

            S_WR_PULSE: begin
               if (cnt_reg == WE_LAST) begin
                  state_reg <= S_WR_HOLD;
                  we_n_reg  <= 1'b1;
                  cnt_reg   <= '0;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end

            // Data stays on the bus one cycle past the rising we for SRAM hold time.
            S_WR_HOLD: begin
               state_reg     <= S_IDLE;
               bus_drive_reg <= 1'b0;
               ready_reg     <= 1'b1;
               busy_reg      <= 1'b0;
            end

            S_RD_SETUP: begin
               state_reg <= S_RD_STROBE;
               oe_n_reg  <= 1'b0;
            end

            // Capture on the edge that ends the strobe, while the SRAM is still driving.
            S_RD_STROBE: begin
               if (cnt_reg == OE_LAST) begin
                  state_reg     <= S_RD_DONE;
                  oe_n_reg      <= 1'b1;
                  rdata_reg     <= mem_data;
                  rsp_valid_reg <= 1'b1;
                  cnt_reg       <= '0;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end

            // Turnaround cycle: neither side drives, so a following write cannot collide.
            S_RD_DONE: begin
               state_reg <= S_IDLE;
               ready_reg <= 1'b1;
               busy_reg  <= 1'b0;
            end

            default: begin
               state_reg     <= S_IDLE;
               cnt_reg       <= '0;
               bus_drive_reg <= 1'b0;
               we_n_reg      <= 1'b1;
               oe_n_reg      <= 1'b1;
               ready_reg     <= 1'b1;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

   assign mem_data  = bus_drive_reg ? wdata_reg : {DATA_W{1'bz}};
   assign mem_addr  = addr_reg;
   assign mem_we    = we_n_reg;
   assign mem_oe    = oe_n_reg;
   assign req_ready = ready_reg;
   assign busy      = busy_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_rdata = rdata_reg;

endmodule
